irq_controller: RTL and testbench
=================================

# irq_controller

Priority interrupt controller that collects single-cycle event pulses from the peripheral blocks on the f8 bus, for example the timer overflow and compare pulses. It latches each pulse as a pending request and presents the CPU with one level interrupt request plus a vector. The block tracks in-service levels so that only a strictly higher-priority source can preempt a handler. Registers follow the same 16-bit, byte-strobed I/O register style as the other peripherals.

## Interface
- NUM_SOURCES, 8: number of interrupt sources, 1..16; source 0 is highest priority.
- clk  input  1  system clock.
- reset  input  1  reset, synchronous, active-low.
- src  input  NUM_SOURCES  event pulses, already synchronous to clk; each high cycle is one event.
- enable_in  input  16  enable register write data.
- enable_write  input  2  byte write strobes for enable: [0] writes bits 7:0, [1] writes bits 15:8.
- pending_clear_in  input  16  write-1-to-clear data for pending.
- pending_clear_write  input  2  byte strobes for pending_clear_in.
- ctrl_in  input  8  control write data; bit0 = global enable (GIE).
- ctrl_write  input  1  control write strobe.
- eoi_write  input  1  end-of-interrupt strobe.
- irq_ack  input  1  CPU acknowledge pulse.
- enable_out, pending_out, in_service_out  output  16  register readback; bits at NUM_SOURCES and above read 0.
- ctrl_out  output  8  control readback.
- irq_out  output  1  interrupt request to the CPU.
- vector_out  output  4  index of the requesting source.

## Operation
- State registers: pending, enable, in_service (each NUM_SOURCES bits) and ctrl (8 bits).
- **Reset** (reset=0 at a clk edge):
  - All state registers clear to 0, so irq_out=0 and vector_out=0.
  - src pulses and writes presented during reset are dropped.
- **Pending**:
  - At each edge, pending[i] is set if src[i]=1.
  - pending[i] is cleared by a pending_clear write with bit i=1, or by an accepted ack whose vector is i.
  - If set and clear hit the same bit in the same cycle, set wins, so no event is lost.
  - Repeated pulses on an already-pending source merge into one request.
- **Candidate selection**:
  - cand = pending & enable.
  - win = lowest set index of cand.
  - isv = lowest set index of in_service; isv = NUM_SOURCES if in_service is empty.
- **Request**:
  - irq_out = GIE && cand != 0 && win < isv.
  - vector_out = win when irq_out=1, else 0.
- **Acknowledge**:
  - irq_ack is accepted only in a cycle where irq_out=1.
  - On acceptance, at the next edge: pending[vector_out] clears and in_service[vector_out] sets.
  - irq_ack while irq_out=0 is ignored.
- **EOI**:
  - eoi_write clears bit isv of in_service.
  - eoi_write with in_service empty has no effect.
- **Simultaneous ack and EOI**: the EOI clears the old isv and the ack sets the new bit, both evaluated on pre-edge state.
- **Disabling**:
  - Clearing an enable bit or GIE leaves pending untouched.
  - irq_out drops in the cycle after the write.
- **Register writes**: take effect at the edge; readback shows the new value in the next cycle.

## Timing
- irq_out and vector_out are combinational from registered state only. There is no combinational path from any input.
- src[i] high in cycle n → pending_out[i] and irq_out high in cycle n+1 (if enabled and unmasked).
- irq_ack in cycle m → irq_out low in cycle m+1, unless a strictly higher-priority candidate exists. If one does, irq_out stays high with the new vector.
- eoi_write in cycle k → a lower-priority request masked by that level appears in cycle k+1.
- Sustained back-to-back pulses on one source produce one pending bit. Re-arm after an ack requires a new pulse on or after the ack cycle.

## Structure
- Package irq_pkg holds:
  - MAX_SOURCES=16;
  - the vector width (4);
  - CTRL_GIE bit position (0);
  - the byte-strobe width (2).
- Sub-module prio_enc: lowest-set-bit encoder with a found flag, parameterised on width. Instantiate it twice, once for cand→win and once for in_service→isv.
- The remaining logic is one clocked always block for the state and one always_comb for the request/vector.

## Test plan
- **Reset**: all outputs 0 after reset; src=8'hFF pulsed during reset → pending_out=0 after release.
- **Single source**:
  - Setup: enable=0x0004, GIE=1; pulse src[2] in cycle n.
  - irq_out=1 and vector_out=2 in cycle n+1.
  - ack → pending_out=0 and in_service_out=0x0004 in the next cycle, with irq_out=0.
- **Priority and nesting**:
  - Setup: sources 1 and 5 pending together.
  - vector_out=1 first; after ack, irq_out=0, since 5 > isv=1.
  - eoi_write → vector_out=5 next cycle.
  - Then pulse src[0] while in_service=0x0020 → preempts with vector_out=0.
- **Set/clear collision**: pending_clear of bit 3 in the same cycle as a src[3] pulse → pending_out[3]=1.
- **Masking**:
  - GIE=0 with pending&enable nonzero → irq_out=0.
  - irq_ack while irq_out=0 → no state change.
  - eoi_write with in_service=0 → no change.
- **Byte writes**: NUM_SOURCES=16; enable_write=2'b10 with enable_in=16'hA5C3 → enable_out=16'hA500 from a reset value of 0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared sizing constants for the priority interrupt controller and its encoder.
package irq_pkg;
   localparam int MAX_SOURCES = 16;
   localparam int VEC_W       = 4;
   localparam int CTRL_GIE    = 0;
   localparam int STRB_W      = 2;
   localparam int BYTE_W      = 8;
endpackage

// File: rtl/irq_controller_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 wins; o_found is low when the input is empty.
module prio_enc
   import irq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_vec,
   output logic [VEC_W-1:0] o_idx,
   output logic             o_found
);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      // Scan downward so the last hit written is the lowest index.
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_idx   = VEC_W'(i);
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Priority interrupt controller: latches event pulses as pending requests and raises one
// level request with a vector, letting only a strictly higher-priority source preempt.
module irq_controller
   import irq_pkg::*;
#(
   parameter int NUM_SOURCES = 8
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [NUM_SOURCES-1:0] i_src,
   input  logic [15:0]            i_enable_in,
   input  logic [STRB_W-1:0]      i_enable_write,
   input  logic [15:0]            i_pending_clear_in,
   input  logic [STRB_W-1:0]      i_pending_clear_write,
   input  logic [7:0]             i_ctrl_in,
   input  logic                   i_ctrl_write,
   input  logic                   i_eoi_write,
   input  logic                   i_irq_ack,
   output logic [15:0]            o_enable_out,
   output logic [15:0]            o_pending_out,
   output logic [15:0]            o_in_service_out,
   output logic [7:0]             o_ctrl_out,
   output logic                   o_irq_out,
   output logic [VEC_W-1:0]       o_vector_out
);

   logic [NUM_SOURCES-1:0] r_pending;
   logic [NUM_SOURCES-1:0] r_enable;
   logic [NUM_SOURCES-1:0] r_in_service;
   logic [7:0]             r_ctrl;

   logic [NUM_SOURCES-1:0] w_cand;
   logic [NUM_SOURCES-1:0] w_clr;
   logic [NUM_SOURCES-1:0] w_ack_hot;
   logic [NUM_SOURCES-1:0] w_eoi_hot;
   logic [VEC_W-1:0]       w_win;
   logic [VEC_W-1:0]       w_isv;
   logic                   w_cand_found;
   logic                   w_isv_found;
   logic                   w_irq;
   logic                   w_ack;
   logic                   w_unused;

   // Register bits that do not exist for narrow configurations are simply ignored.
   assign w_unused = ^{i_enable_in, i_pending_clear_in, i_enable_write, i_pending_clear_write};

   assign w_cand = r_pending & r_enable;

   prio_enc #(.WIDTH(NUM_SOURCES)) u_win_enc (
      .i_vec   (w_cand),
      .o_idx   (w_win),
      .o_found (w_cand_found)
   );

   prio_enc #(.WIDTH(NUM_SOURCES)) u_isv_enc (
      .i_vec   (r_in_service),
      .o_idx   (w_isv),
      .o_found (w_isv_found)
   );

   always_comb begin
      o_enable_out     = '0;
      o_pending_out    = '0;
      o_in_service_out = '0;
      o_enable_out[NUM_SOURCES-1:0]     = r_enable;
      o_pending_out[NUM_SOURCES-1:0]    = r_pending;
      o_in_service_out[NUM_SOURCES-1:0] = r_in_service;
      o_ctrl_out = r_ctrl;

      // An empty in-service set behaves as level NUM_SOURCES, below every real source.
      w_irq        = r_ctrl[CTRL_GIE] && w_cand_found && (!w_isv_found || (w_win < w_isv));
      o_irq_out    = w_irq;
      o_vector_out = w_irq ? w_win : '0;

      w_ack     = i_irq_ack && w_irq;
      w_ack_hot = w_ack ? (NUM_SOURCES'(1) << w_win) : '0;
      w_eoi_hot = (i_eoi_write && w_isv_found) ? (NUM_SOURCES'(1) << w_isv) : '0;

      w_clr = '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         w_clr[i] = i_pending_clear_write[i / BYTE_W] & i_pending_clear_in[i];
      end
   end

   // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_pending    <= '0;
         r_enable     <= '0;
         r_in_service <= '0;
         r_ctrl       <= '0;
      end else begin
         // New pulses are OR-ed in last so a same-cycle clear never loses an event.
         r_pending    <= (r_pending & ~w_clr & ~w_ack_hot) | i_src;
         r_in_service <= (r_in_service & ~w_eoi_hot) | w_ack_hot;
         if (i_ctrl_write) begin
            r_ctrl <= i_ctrl_in;
         end
         for (int i = 0; i < NUM_SOURCES; i++) begin
            if (i_enable_write[i / BYTE_W]) begin
               r_enable[i] <= i_enable_in[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_irq_controller.sv
// Directed, table-driven bench for irq_controller (8-source instance) plus an extra
// 16-source instance exercising upper-byte writes and the highest vector.
module tb_irq_controller;

   logic       clk;
   logic       reset;

   logic [7:0]  src;
   logic [15:0] enable_in;
   logic [1:0]  enable_write;
   logic [15:0] clr_in;
   logic [1:0]  clr_write;
   logic [7:0]  ctrl_in;
   logic        ctrl_write;
   logic        eoi;
   logic        ack;
   logic [15:0] enable_out, pending_out, in_service_out;
   logic [7:0]  ctrl_out;
   logic        irq_out;
   logic [3:0]  vector_out;

   logic [15:0] b_src;
   logic [15:0] b_enable_in;
   logic [1:0]  b_enable_write;
   logic [15:0] b_clr_in;
   logic [1:0]  b_clr_write;
   logic [7:0]  b_ctrl_in;
   logic        b_ctrl_write;
   logic        b_eoi;
   logic        b_ack;
   logic [15:0] b_enable_out, b_pending_out, b_in_service_out;
   logic [7:0]  b_ctrl_out;
   logic        b_irq_out;
   logic [3:0]  b_vector_out;

   int n_vec = 0;
   int n_err = 0;

   irq_controller #(.NUM_SOURCES(8)) dut (
      .i_clk                 (clk),
      .i_reset               (reset),
      .i_src                 (src),
      .i_enable_in           (enable_in),
      .i_enable_write        (enable_write),
      .i_pending_clear_in    (clr_in),
      .i_pending_clear_write (clr_write),
      .i_ctrl_in             (ctrl_in),
      .i_ctrl_write          (ctrl_write),
      .i_eoi_write           (eoi),
      .i_irq_ack             (ack),
      .o_enable_out          (enable_out),
      .o_pending_out         (pending_out),
      .o_in_service_out      (in_service_out),
      .o_ctrl_out            (ctrl_out),
      .o_irq_out             (irq_out),
      .o_vector_out          (vector_out)
   );

   irq_controller #(.NUM_SOURCES(16)) dut16 (
      .i_clk                 (clk),
      .i_reset               (reset),
      .i_src                 (b_src),
      .i_enable_in           (b_enable_in),
      .i_enable_write        (b_enable_write),
      .i_pending_clear_in    (b_clr_in),
      .i_pending_clear_write (b_clr_write),
      .i_ctrl_in             (b_ctrl_in),
      .i_ctrl_write          (b_ctrl_write),
      .i_eoi_write           (b_eoi),
      .i_irq_ack             (b_ack),
      .o_enable_out          (b_enable_out),
      .o_pending_out         (b_pending_out),
      .o_in_service_out      (b_in_service_out),
      .o_ctrl_out            (b_ctrl_out),
      .o_irq_out             (b_irq_out),
      .o_vector_out          (b_vector_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0]  src;
      logic [1:0]  ew;
      logic [15:0] ein;
      logic [1:0]  cw;
      logic [15:0] cin;
      logic        ctw;
      logic [7:0]  ctin;
      logic        eoi;
      logic        ack;
      logic        irq;
      logic [3:0]  vec;
      logic [15:0] pend;
      logic [15:0] isv;
      logic [15:0] en;
      logic [7:0]  ctrl;
   } row_t;

   row_t        tbl[$];
   logic [15:0] cur_en   = '0;
   logic [7:0]  cur_ctrl = '0;

   // Expected enable/ctrl follow the writes in each row; the 8-source part has no upper byte.
   task automatic add(input logic [7:0] s, input logic [1:0] ew, input logic [15:0] ein,
                      input logic [1:0] cw, input logic [15:0] cin, input logic ctw,
                      input logic [7:0] ctin, input logic e, input logic a,
                      input logic irq, input logic [3:0] vec, input logic [15:0] pend,
                      input logic [15:0] isv);
      row_t r;
      if (ew[0]) cur_en[7:0] = ein[7:0];
      cur_en = cur_en & 16'h00FF;
      if (ctw) cur_ctrl = ctin;
      r.src = s;  r.ew = ew;  r.ein = ein;  r.cw = cw;  r.cin = cin;
      r.ctw = ctw; r.ctin = ctin; r.eoi = e; r.ack = a;
      r.irq = irq; r.vec = vec; r.pend = pend; r.isv = isv;
      r.en = cur_en; r.ctrl = cur_ctrl;
      tbl.push_back(r);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      src = '0; enable_in = '0; enable_write = '0; clr_in = '0; clr_write = '0;
      ctrl_in = '0; ctrl_write = 1'b0; eoi = 1'b0; ack = 1'b0;
      b_src = '0; b_enable_in = '0; b_enable_write = '0; b_clr_in = '0; b_clr_write = '0;
      b_ctrl_in = '0; b_ctrl_write = 1'b0; b_eoi = 1'b0; b_ack = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---------------- table ----------------
      //   src   ew  ein        cw  cin        ctw ctin  eoi ack | irq vec pend   isv
      add(8'h00, 1, 16'h0004, 0, 16'h0000, 0, 8'h00, 0, 0,  0, 0, 16'h00, 16'h00); // 0 enable src2
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 1, 8'h01, 0, 0,  0, 0, 16'h00, 16'h00); // 1 GIE
      add(8'h04, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 0,  1, 2, 16'h04, 16'h00); // 2 pulse src2
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 0,  1, 2, 16'h04, 16'h00); // 3 level held
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 1,  0, 0, 16'h00, 16'h04); // 4 ack
      add(8'h04, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 0,  0, 0, 16'h04, 16'h04); // 5 same level masked
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 1, 0,  1, 2, 16'h04, 16'h00); // 6 eoi unmasks
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 1,  0, 0, 16'h00, 16'h04); // 7
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 1, 0,  0, 0, 16'h00, 16'h00); // 8
      add(8'h00, 1, 16'h00FF, 0, 16'h0000, 0, 8'h00, 0, 0,  0, 0, 16'h00, 16'h00); // 9 enable all
      add(8'h22, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 0,  1, 1, 16'h22, 16'h00); // 10 src1+src5
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 1,  0, 0, 16'h20, 16'h02); // 11 5 masked by 1
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 1, 0,  1, 5, 16'h20, 16'h00); // 12 eoi -> vec5
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 1,  0, 0, 16'h00, 16'h20); // 13
      add(8'h01, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 0,  1, 0, 16'h01, 16'h20); // 14 src0 preempts
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 1,  0, 0, 16'h00, 16'h21); // 15 nested
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 1, 0,  0, 0, 16'h00, 16'h20); // 16 eoi clears 0
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 1, 0,  0, 0, 16'h00, 16'h00); // 17 eoi clears 5
      add(8'h08, 0, 16'h0000, 1, 16'h0008, 0, 8'h00, 0, 0,  1, 3, 16'h08, 16'h00); // 18 set beats clear
      add(8'h00, 0, 16'h0000, 1, 16'h0008, 0, 8'h00, 0, 0,  0, 0, 16'h00, 16'h00); // 19 clear
      add(8'h10, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 0,  1, 4, 16'h10, 16'h00); // 20
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 1, 8'h00, 0, 0,  0, 0, 16'h10, 16'h00); // 21 GIE off
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 1,  0, 0, 16'h10, 16'h00); // 22 ack ignored
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 1, 0,  0, 0, 16'h10, 16'h00); // 23 eoi no-op
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 1, 8'h01, 0, 0,  1, 4, 16'h10, 16'h00); // 24 GIE on
      add(8'h00, 1, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 0,  0, 0, 16'h10, 16'h00); // 25 disable
      add(8'h00, 3, 16'hFFFF, 0, 16'h0000, 0, 8'h00, 0, 0,  1, 4, 16'h10, 16'h00); // 26 re-enable
      add(8'h10, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 1,  0, 0, 16'h10, 16'h10); // 27 re-arm on ack
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 1, 0,  1, 4, 16'h10, 16'h00); // 28
      add(8'h00, 0, 16'h0000, 2, 16'hFFFF, 0, 8'h00, 0, 0,  1, 4, 16'h10, 16'h00); // 29 upper clr only
      add(8'h00, 0, 16'h0000, 1, 16'h0010, 0, 8'h00, 0, 0,  0, 0, 16'h00, 16'h00); // 30
      add(8'h20, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 0,  1, 5, 16'h20, 16'h00); // 31
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 1,  0, 0, 16'h00, 16'h20); // 32
      add(8'h01, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 0,  1, 0, 16'h01, 16'h20); // 33
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 1, 1,  0, 0, 16'h00, 16'h01); // 34 ack+eoi
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 1, 0,  0, 0, 16'h00, 16'h00); // 35
      add(8'h40, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 0,  1, 6, 16'h40, 16'h00); // 36 sustained
      add(8'h40, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 0,  1, 6, 16'h40, 16'h00); // 37
      add(8'h40, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 0,  1, 6, 16'h40, 16'h00); // 38
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 1,  0, 0, 16'h00, 16'h40); // 39 one request
      add(8'h00, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 1, 0,  0, 0, 16'h00, 16'h00); // 40

      // ---------------- reset: pulses and writes during reset are dropped ----------------
      idle_inputs();
      reset = 1'b0;
      src = 8'hFF; enable_in = 16'hFFFF; enable_write = 2'b11; ctrl_in = 8'hFF; ctrl_write = 1'b1;
      step();
      step();
      check("rst_irq",     irq_out,        1'b0);
      check("rst_vector",  vector_out,     4'h0);
      check("rst_pending", pending_out,    16'h0000);
      check("rst_enable",  enable_out,     16'h0000);
      check("rst_ctrl",    ctrl_out,       8'h00);
      idle_inputs();
      reset = 1'b1;
      step();
      check("post_rst_pending", pending_out,    16'h0000);
      check("post_rst_insvc",   in_service_out, 16'h0000);
      check("post_rst_irq",     irq_out,        1'b0);
      check("post_rst_enable",  enable_out,     16'h0000);

      // ---------------- table replay ----------------
      foreach (tbl[k]) begin
         src = tbl[k].src; enable_write = tbl[k].ew; enable_in = tbl[k].ein;
         clr_write = tbl[k].cw; clr_in = tbl[k].cin; ctrl_write = tbl[k].ctw;
         ctrl_in = tbl[k].ctin; eoi = tbl[k].eoi; ack = tbl[k].ack;
         step();
         idle_inputs();
         check($sformatf("row%0d_irq", k),     irq_out,        tbl[k].irq);
         check($sformatf("row%0d_vector", k),  vector_out,     tbl[k].vec);
         check($sformatf("row%0d_pending", k), pending_out,    tbl[k].pend);
         check($sformatf("row%0d_insvc", k),   in_service_out, tbl[k].isv);
         check($sformatf("row%0d_enable", k),  enable_out,     tbl[k].en);
         check($sformatf("row%0d_ctrl", k),    ctrl_out,       tbl[k].ctrl);
      end

      // ---------------- 16-source instance: upper byte strobe and vector 15 ----------------
      idle_inputs();
      b_enable_in = 16'hA5C3; b_enable_write = 2'b10;
      step();
      idle_inputs();
      check("w16_enable_hi_only", b_enable_out, 16'hA500);
      b_ctrl_in = 8'h01; b_ctrl_write = 1'b1; b_src = 16'h8000;
      step();
      idle_inputs();
      check("w16_pending15", b_pending_out, 16'h8000);
      check("w16_irq15",     b_irq_out,     1'b1);
      check("w16_vector15",  b_vector_out,  4'hF);
      b_clr_in = 16'h80FF; b_clr_write = 2'b01;
      step();
      idle_inputs();
      check("w16_lo_clr_keeps15", b_pending_out, 16'h8000);
      b_clr_in = 16'h8000; b_clr_write = 2'b10;
      step();
      idle_inputs();
      check("w16_hi_clr",  b_pending_out, 16'h0000);
      check("w16_irq_off", b_irq_out,     1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
